dcache_wt: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache.
- Sits directly downstream of the core's Memory stage. It consumes the core's dreq/dwrite/daddr/dsize/ddata requests and returns read data with the dready_n/dbusy handshake the core's stall logic uses.
- Misses and all stores are forwarded to a single-outstanding external memory port.

---
 rtl/dcache_wt_if.sv | 25 ++
 rtl/dcache_wt.sv | 180 ++++++++++++++++++
 tb/tb_dcache_wt.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_wt_if.sv
// dcache_wt_if: external memory port used by the write-through data cache.
// One request is outstanding at a time: m_req (with m_we/m_addr/m_wdata/
// m_wstrb) is held until the memory returns a single-cycle m_ack pulse.
// On a read, m_rdata is valid in the cycle of m_ack.
//   master modport : the cache (drives the request, receives ack/data)
//   slave  modport : the memory (receives the request, drives ack/data)
interface dcache_wt_if;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic        m_ack;

    modport master (
        output m_req, m_we, m_addr, m_wdata, m_wstrb,
        input  m_rdata, m_ack
    );

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, m_wstrb,
        output m_rdata, m_ack
    );
endinterface

// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate data cache with
// one-word lines, placed right after the core's Memory stage.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   dreq, dwrite    core request and store/load select
//   daddr, dsize    byte address and access size (00 byte, 01 half, else word)
//   ddata           right-aligned store data
//   rdata           full aligned load word (valid while dready_n is low)
//   dready_n        active-low load-data-valid, asserted combinationally on a hit
//   dbusy           high while a memory transaction is in flight
//   inv             invalidate every line
//   mem             external memory port (dcache_wt_if.master)
module dcache_wt #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dreq,
    input  logic        dwrite,
    input  logic [31:0] daddr,
    input  logic [1:0]  dsize,
    input  logic [31:0] ddata,
    output logic [31:0] rdata,
    output logic        dready_n,
    output logic        dbusy,
    input  logic        inv,
    dcache_wt_if.master mem
);
    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

    state_t                state;
    state_t                next_state;
    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tag_mem [LINES];
    logic [31:0]           data_mem [LINES];

    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic [INDEX_BITS-1:0] lat_index;
    logic [TAG_BITS-1:0]   lat_tag;
    logic                  hit;
    logic                  load_hit;
    logic                  load_miss;
    logic                  store_req;
    logic                  store_hit;
    logic [31:0]           lane_data;
    logic [3:0]            lane_strb;
    logic [31:0]           m_addr_q;
    logic [31:0]           m_wdata_q;
    logic [3:0]            m_wstrb_q;
    logic                  req_c;
    logic                  we_c;

    assign index     = daddr[INDEX_BITS+1:2];
    assign tag       = daddr[31:INDEX_BITS+2];
    assign hit       = valid[index] && (tag_mem[index] == tag);
    assign load_hit  = (state == IDLE) && dreq && !dwrite && hit;
    assign load_miss = (state == IDLE) && dreq && !dwrite && !hit;
    assign store_req = (state == IDLE) && dreq && dwrite;
    assign store_hit = store_req && hit;

    // Replicate store data across the byte lanes and pick the strobes.
    // Misaligned low address bits are simply ignored for halves and words.
    always_comb begin
        lane_data = ddata;
        lane_strb = 4'b1111;
        case (dsize)
            2'b00: begin
                lane_data = {4{ddata[7:0]}};
                lane_strb = 4'b0001 << daddr[1:0];
            end
            2'b01: begin
                lane_data = {2{ddata[15:0]}};
                lane_strb = 4'b0011 << {daddr[1], 1'b0};
            end
            default: begin
                lane_data = ddata;
                lane_strb = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // m_req/m_we come straight from the state so that a reset drops the
    // request immediately rather than at the next edge.
    always_comb begin
        next_state = state;
        dbusy      = 1'b0;
        dready_n   = 1'b1;
        rdata      = '0;
        req_c      = 1'b0;
        we_c       = 1'b0;
        case (state)
            IDLE: begin
                if (load_hit) begin
                    dready_n = 1'b0;
                    rdata    = data_mem[index];
                end else if (load_miss) begin
                    next_state = RD_MISS;
                end else if (store_req) begin
                    next_state = WR_THRU;
                end
            end
            RD_MISS: begin
                dbusy = 1'b1;
                req_c = 1'b1;
                if (mem.m_ack) next_state = IDLE;
            end
            WR_THRU: begin
                dbusy = 1'b1;
                req_c = 1'b1;
                we_c  = 1'b1;
                if (mem.m_ack) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request payload is captured when a transaction starts and cleared when
    // it completes, so the bus reads all-zero whenever the cache is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wstrb_q <= '0;
            lat_index <= '0;
            lat_tag   <= '0;
        end else if (state == IDLE) begin
            if (load_miss) begin
                m_addr_q  <= {daddr[31:2], 2'b00};
                m_wdata_q <= '0;
                m_wstrb_q <= '0;
                lat_index <= index;
                lat_tag   <= tag;
            end else if (store_req) begin
                m_addr_q  <= {daddr[31:2], 2'b00};
                m_wdata_q <= lane_data;
                m_wstrb_q <= lane_strb;
            end
        end else if (mem.m_ack) begin
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wstrb_q <= '0;
        end
    end

    // inv wins over a completing fill, so a line filled on an inv edge stays
    // invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               valid <= '0;
        else if (inv)                          valid <= '0;
        else if (state == RD_MISS && mem.m_ack) valid[lat_index] <= 1'b1;
    end

    // Tag/data arrays need no reset; valid guards them. Store hits merge only
    // the strobed bytes, store misses leave the array alone.
    always_ff @(posedge clk) begin
        if (state == RD_MISS && mem.m_ack) begin
            data_mem[lat_index] <= mem.m_rdata;
            tag_mem[lat_index]  <= lat_tag;
        end else if (store_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_strb[b]) data_mem[index][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
    end

    assign mem.m_req   = req_c;
    assign mem.m_we    = we_c;
    assign mem.m_addr  = m_addr_q;
    assign mem.m_wdata = m_wdata_q;
    assign mem.m_wstrb = m_wstrb_q;
endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: self-checking bench for dcache_wt. The bench acts as both the
// core and the external memory. A behavioural model (line valid/word-address/
// data per index plus a sparse backing memory) decides hit or miss for every
// access and what each cycle's outputs must be; one compare process checks
// the DUT on every falling edge. Directed scenarios with literal expectations
// come first, then randomized traffic.
module tb_dcache_wt;
    localparam int INDEX_BITS = 6;
    localparam int LINES      = 1 << INDEX_BITS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dreq = 1'b0;
    logic        dwrite = 1'b0;
    logic [31:0] daddr = '0;
    logic [1:0]  dsize = '0;
    logic [31:0] ddata = '0;
    logic        inv = 1'b0;
    logic [31:0] rdata;
    logic        dready_n;
    logic        dbusy;

    dcache_wt_if mem_bus ();

    dcache_wt #(.INDEX_BITS(INDEX_BITS)) dut (
        .clk(clk), .rst(rst), .dreq(dreq), .dwrite(dwrite), .daddr(daddr),
        .dsize(dsize), .ddata(ddata), .rdata(rdata), .dready_n(dready_n),
        .dbusy(dbusy), .inv(inv), .mem(mem_bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Model state: each line remembers the word address it holds.
    bit          mv    [LINES];
    logic [29:0] mline [LINES];
    logic [31:0] mdata [LINES];
    logic [31:0] mem   [logic [29:0]];

    // Per-cycle expectations consumed by the compare process.
    bit          check_en = 1'b0;
    logic        exp_dready_n, exp_dbusy, exp_m_req, exp_m_we;
    logic [31:0] exp_rdata, exp_m_addr, exp_m_wdata;
    logic [3:0]  exp_m_wstrb;
    logic [31:0] seen_rdata, seen_wdata;
    logic [3:0]  seen_wstrb;
    int          last_lat;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("dready_n", dready_n, exp_dready_n);
            checkOutput("dbusy", dbusy, exp_dbusy);
            checkOutput("m_req", mem_bus.m_req, exp_m_req);
            checkOutput("m_we", mem_bus.m_we, exp_m_we);
            if (!exp_dready_n) begin
                checkOutput("rdata", rdata, exp_rdata);
                seen_rdata = rdata;
            end
            if (exp_m_req) begin
                checkOutput("m_addr", mem_bus.m_addr, exp_m_addr);
                if (exp_m_we) begin
                    checkOutput("m_wdata", mem_bus.m_wdata, exp_m_wdata);
                    checkOutput("m_wstrb", mem_bus.m_wstrb, exp_m_wstrb);
                    seen_wdata = mem_bus.m_wdata;
                    seen_wstrb = mem_bus.m_wstrb;
                end
            end
        end
    end

    function automatic int line_of(input logic [31:0] a);
        return int'(a[31:2]) % LINES;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return mv[line_of(a)] && (mline[line_of(a)] == a[31:2]);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a[31:2])) return mem[a[31:2]];
        return {a[31:2], 2'b00} ^ 32'h5A5A_1234;
    endfunction

    // Bytes of the word touched by a store of the given size.
    function automatic logic [3:0] byte_mask(input logic [31:0] a, input logic [1:0] sz);
        case (sz)
            2'd0:    return 4'b0001 << a[1:0];
            2'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data as it appears on the byte lanes: the source bytes repeat.
    function automatic logic [31:0] bus_data(input logic [31:0] d, input logic [1:0] sz);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            case (sz)
                2'd0:    r[8*b +: 8] = d[7:0];
                2'd1:    r[8*b +: 8] = d[8*(b%2) +: 8];
                default: r[8*b +: 8] = d[8*b +: 8];
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        exp_dready_n = 1'b1;
        exp_dbusy    = 1'b0;
        exp_m_req    = 1'b0;
        exp_m_we     = 1'b0;
        exp_rdata    = '0;
        exp_m_addr   = '0;
        exp_m_wdata  = '0;
        exp_m_wstrb  = '0;
    endtask

    task automatic clear_valid();
        for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
    endtask

    task automatic idle_cycle(input bit do_inv);
        dreq  = 1'b0;
        ddata = $urandom;
        inv   = do_inv;
        set_idle_exp();
        tick();
        inv = 1'b0;
        if (do_inv) clear_valid();
    endtask

    // One complete core access, including the stall and the memory side.
    task automatic applyStimulus(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                                 input logic [31:0] d, input int lat, input bit do_inv);
        int          cyc = 0;
        bit          inv_pending = do_inv;
        logic [31:0] word;
        dreq = 1'b1; dwrite = wr; daddr = a; dsize = sz; ddata = d;
        if (!wr) begin
            forever begin
                if (model_hit(a)) begin
                    set_idle_exp();
                    exp_dready_n = 1'b0;
                    exp_rdata    = mdata[line_of(a)];
                    tick();
                    break;
                end
                set_idle_exp();
                tick(); cyc++;
                word = mem_word(a);
                for (int k = 1; k <= lat; k++) begin
                    set_idle_exp();
                    exp_dbusy  = 1'b1;
                    exp_m_req  = 1'b1;
                    exp_m_addr = {a[31:2], 2'b00};
                    mem_bus.m_ack   = (k == lat);
                    mem_bus.m_rdata = (k == lat) ? word : $urandom;
                    inv = (k == lat) && inv_pending;
                    tick(); cyc++;
                end
                mem_bus.m_ack = 1'b0;
                mline[line_of(a)] = a[31:2];
                mdata[line_of(a)] = word;
                if (inv) clear_valid();
                else     mv[line_of(a)] = 1'b1;
                inv = 1'b0;
                inv_pending = 1'b0;
            end
        end else begin
            set_idle_exp();
            inv = do_inv;
            tick(); cyc++;
            inv = 1'b0;
            if (model_hit(a))
                mdata[line_of(a)] = merge(mdata[line_of(a)], bus_data(d, sz), byte_mask(a, sz));
            if (do_inv) clear_valid();
            for (int k = 1; k <= lat; k++) begin
                set_idle_exp();
                exp_dbusy   = 1'b1;
                exp_m_req   = 1'b1;
                exp_m_we    = 1'b1;
                exp_m_addr  = {a[31:2], 2'b00};
                exp_m_wdata = bus_data(d, sz);
                exp_m_wstrb = byte_mask(a, sz);
                mem_bus.m_ack = (k == lat);
                tick(); cyc++;
            end
            mem_bus.m_ack = 1'b0;
            mem[a[31:2]] = merge(mem_word(a), bus_data(d, sz), byte_mask(a, sz));
        end
        last_lat = cyc;
    endtask

    initial begin
        mem_bus.m_ack   = 1'b0;
        mem_bus.m_rdata = '0;
        clear_valid();
        set_idle_exp();
        mem[30'h40] = 32'hDEADBEEF;
        mem[30'h80] = 32'h1234_5678;

        repeat (2) @(negedge clk);
        checkOutput("reset dready_n", dready_n, 1'b1);
        checkOutput("reset dbusy", dbusy, 1'b0);
        checkOutput("reset m_req", mem_bus.m_req, 1'b0);
        checkOutput("reset m_we", mem_bus.m_we, 1'b0);
        checkOutput("reset m_addr", mem_bus.m_addr, 32'h0);
        checkOutput("reset m_wdata", mem_bus.m_wdata, 32'h0);
        checkOutput("reset m_wstrb", mem_bus.m_wstrb, 4'h0);
        checkOutput("reset rdata", rdata, 32'h0);
        rst = 1'b0;
        tick();
        check_en = 1'b1;

        // Cold miss with a three-cycle memory.
        applyStimulus(1'b0, 32'h100, 2'd2, 32'h0, 3, 1'b0);
        checkOutput("s1 miss latency", last_lat, 4);
        checkOutput("s1 rdata", seen_rdata, 32'hDEADBEEF);
        // Same load hits in the presentation cycle.
        applyStimulus(1'b0, 32'h100, 2'd2, 32'h0, 1, 1'b0);
        checkOutput("s2 hit latency", last_lat, 0);
        // Byte store into the top lane updates the cached line.
        applyStimulus(1'b1, 32'h103, 2'd0, 32'h0000_00AA, 2, 1'b0);
        checkOutput("s3 wstrb", seen_wstrb, 4'b1000);
        checkOutput("s3 wdata", seen_wdata, 32'hAAAAAAAA);
        applyStimulus(1'b0, 32'h100, 2'd2, 32'h0, 1, 1'b0);
        checkOutput("s3 hit latency", last_lat, 0);
        checkOutput("s3 rdata", seen_rdata, 32'hAAADBEEF);
        // Conflicting tag evicts the line.
        applyStimulus(1'b0, 32'h200, 2'd2, 32'h0, 2, 1'b0);
        checkOutput("s4 conflict miss", last_lat, 3);
        checkOutput("s4 rdata", seen_rdata, 32'h1234_5678);
        applyStimulus(1'b0, 32'h100, 2'd2, 32'h0, 1, 1'b0);
        checkOutput("s4 refetch miss", last_lat, 2);
        checkOutput("s4 refetch rdata", seen_rdata, 32'hAAADBEEF);
        // Invalidate while idle.
        idle_cycle(1'b1);
        applyStimulus(1'b0, 32'h100, 2'd2, 32'h0, 2, 1'b0);
        checkOutput("s5 miss after inv", last_lat, 3);

        // Reset in the middle of a read miss, then a stray ack.
        dreq = 1'b1; dwrite = 1'b0; daddr = 32'h340; dsize = 2'd2;
        set_idle_exp();
        tick();
        exp_dbusy = 1'b1; exp_m_req = 1'b1; exp_m_addr = 32'h340;
        tick();
        check_en = 1'b0;
        #1 rst = 1'b1;
        #1;
        checkOutput("s6 m_req in reset", mem_bus.m_req, 1'b0);
        checkOutput("s6 dbusy in reset", dbusy, 1'b0);
        checkOutput("s6 dready_n in reset", dready_n, 1'b1);
        dreq = 1'b0;
        clear_valid();
        tick();
        rst = 1'b0;
        set_idle_exp();
        check_en = 1'b1;
        mem_bus.m_ack   = 1'b1;
        mem_bus.m_rdata = 32'hBAD0BAD0;
        tick();
        mem_bus.m_ack = 1'b0;
        applyStimulus(1'b0, 32'h340, 2'd2, 32'h0, 2, 1'b0);
        checkOutput("s6 miss after reset", last_lat, 3);

        // Random traffic over a few tags and indices to provoke hits and conflicts.
        for (int n = 0; n < 300; n++) begin
            int          op = $urandom_range(0, 9);
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            if (op < 2)
                idle_cycle($urandom_range(0, 3) == 0);
            else
                applyStimulus(op >= 6, a, 2'($urandom_range(0, 3)), $urandom,
                              $urandom_range(1, 4), $urandom_range(0, 9) == 0);
        end
        idle_cycle(1'b0);
        check_en = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
